// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: per-source result FIFOs, round-robin onto NUM_WP write ports, pending scoreboard.
// Define WB_R0_DISCARD_EN to consume writes to r0 without ever queueing them.
module reg_wb_arbiter #(
  parameter int NUM_SRC    = 5,
  parameter int NUM_WP     = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*5-1:0]    src_addr,
  input  logic [NUM_SRC*32-1:0]   src_data,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic [NUM_WP-1:0]       wp_en,
  output logic [NUM_WP*5-1:0]     wp_addr,
  output logic [NUM_WP*32-1:0]    wp_data,
  output logic [31:0]             pending
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  logic [4:0]          addr_q [NUM_SRC][FIFO_DEPTH];
  logic [31:0]         data_q [NUM_SRC][FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr [NUM_SRC];
  logic [AW-1:0]       wr_ptr [NUM_SRC];
  logic [CW-1:0]       count  [NUM_SRC];
  logic [SW-1:0]       rr_ptr, rr_nxt, idx, last;
  logic [NUM_SRC-1:0]  push, grant;
  logic [NUM_WP-1:0]   nxt_en;
  logic [NUM_WP*5-1:0] nxt_addr;
  logic [NUM_WP*32-1:0] nxt_data;
  logic                placed, conflict;
  logic [31:0]         pend;
  always_comb begin
    src_ready = '0;
    push = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !rst && count[i] != CW'(FIFO_DEPTH);
`ifdef WB_R0_DISCARD_EN
      push[i] = src_valid[i] && src_ready[i] && src_addr[5*i +: 5] != 5'd0;
`else
      push[i] = src_valid[i] && src_ready[i];
`endif
    end
  end
  // Grants fill ports in scan order, so the first free port is always the k-th grant.
  always_comb begin
    grant = '0;
    nxt_en = '0;
    nxt_addr = '0;
    nxt_data = '0;
    last = rr_ptr;
    idx = '0;
    placed = 1'b0;
    conflict = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = SW'((int'(rr_ptr) + j) % NUM_SRC);
      conflict = 1'b0;
      for (int k = 0; k < NUM_WP; k++)
        conflict |= nxt_en[k] && nxt_addr[5*k +: 5] == addr_q[idx][rd_ptr[idx]];
      placed = 1'b0;
      for (int k = 0; k < NUM_WP; k++)
        if (count[idx] != '0 && !conflict && !placed && !nxt_en[k]) begin
          nxt_en[k] = 1'b1;
          nxt_addr[5*k +: 5] = addr_q[idx][rd_ptr[idx]];
          nxt_data[32*k +: 32] = data_q[idx][rd_ptr[idx]];
          grant[idx] = 1'b1;
          last = idx;
          placed = 1'b1;
        end
    end
    rr_nxt = !(|grant) ? rr_ptr : (last == SW'(NUM_SRC - 1)) ? '0 : last + 1'b1;
  end
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int e = 0; e < FIFO_DEPTH; e++)
        if ({1'b0, AW'(AW'(e) - rd_ptr[i])} < count[i]) pend[addr_q[i][e]] = 1'b1;
    for (int k = 0; k < NUM_WP; k++)
      if (wp_en[k]) pend[wp_addr[5*k +: 5]] = 1'b1;
    pending = rst ? '0 : pend;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      wp_en <= '0;
      wp_addr <= '0;
      wp_data <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i] <= '0;
      end
    end else begin
      rr_ptr <= rr_nxt;
      wp_en <= nxt_en;
      wp_addr <= nxt_addr;
      wp_data <= nxt_data;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          addr_q[i][wr_ptr[i]] <= src_addr[5*i +: 5];
          data_q[i][wr_ptr[i]] <= src_data[32*i +: 32];
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(grant[i]);
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: queue-based reference model feeding a scoreboard checked by a separate monitor.
module tb_reg_wb_arbiter;
  localparam int NS = 5, NW = 2, D = 2;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} item_t;
  typedef struct packed {logic [NW-1:0] en; logic [NW*5-1:0] a; logic [NW*32-1:0] d;} wp_t;
  logic clk = 0, rst = 1;
  logic [NS-1:0] src_valid = '1, src_ready;
  logic [NS*5-1:0] src_addr = '0;
  logic [NS*32-1:0] src_data = '0;
  logic [NW-1:0] wp_en;
  logic [NW*5-1:0] wp_addr;
  logic [NW*32-1:0] wp_data;
  logic [31:0] pending;
  item_t stim[NS][$];
  item_t mq[NS][$];
  wp_t exp_q[$];
  logic [NS-1:0] acc = '0;
  int rr = 0, n_cmp = 0, n_err = 0, s, gn, last;
  bit was_rst = 1, hit;
  wp_t e, w;
  reg_wb_arbiter dut (.clk(clk), .rst(rst), .src_valid(src_valid), .src_addr(src_addr),
    .src_data(src_data), .src_ready(src_ready), .wp_en(wp_en), .wp_addr(wp_addr),
    .wp_data(wp_data), .pending(pending));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask
  // Reference: per-source queues, each cycle grant up to NW distinct-address heads in RR order.
  always @(posedge clk) begin
    e = '0;
    if (rst) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      rr = 0;
      acc = '0;
    end else begin
      for (int i = 0; i < NS; i++) acc[i] = src_valid[i] && mq[i].size() < D;
      gn = 0;
      last = -1;
      for (int j = 0; j < NS; j++) begin
        s = (rr + j) % NS;
        if (mq[s].size() == 0 || gn == NW) continue;
        hit = 0;
        for (int k = 0; k < gn; k++) if (e.a[k*5 +: 5] == mq[s][0].a) hit = 1;
        if (hit) continue;
        e.en[gn] = 1'b1;
        e.a[gn*5 +: 5] = mq[s][0].a;
        e.d[gn*32 +: 32] = mq[s][0].d;
        void'(mq[s].pop_front());
        gn++;
        last = s;
      end
      if (last >= 0) rr = (last + 1) % NS;
      for (int i = 0; i < NS; i++)
`ifdef WB_R0_DISCARD_EN
        if (acc[i] && src_addr[i*5 +: 5] != 5'd0)
`else
        if (acc[i])
`endif
          mq[i].push_back({src_addr[i*5 +: 5], src_data[i*32 +: 32]});
    end
    exp_q.push_back(e);
  end
  function automatic logic [31:0] exp_pend(input wp_t x);
    logic [31:0] p = '0;
    for (int i = 0; i < NS; i++)
      for (int m = 0; m < mq[i].size(); m++) p[mq[i][m].a] = 1'b1;
    for (int k = 0; k < NW; k++) if (x.en[k]) p[x.a[k*5 +: 5]] = 1'b1;
    return p;
  endfunction
  initial forever begin
    logic [NS-1:0] r;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      w = exp_q.pop_front();
      for (int i = 0; i < NS; i++) r[i] = !rst && mq[i].size() < D;
      check("wp", 256'({wp_en, wp_addr, wp_data}), 256'(w));
      check("src_ready", 256'(src_ready), 256'(r));
      check("pending", 256'(pending), rst ? 256'(0) : 256'(exp_pend(w)));
    end
  end
  task automatic step(input int rate, input bit r);
    @(negedge clk);
    rst = r;
    if (r) src_valid = '1;
    else for (int i = 0; i < NS; i++) begin
      if (acc[i]) void'(stim[i].pop_front());
      if (was_rst || !src_valid[i] || acc[i]) begin
        src_valid[i] = stim[i].size() > 0 && $urandom_range(0, 99) < rate;
        if (stim[i].size() > 0) {src_addr[i*5 +: 5], src_data[i*32 +: 32]} = stim[i][0];
      end
    end
    was_rst = r;
  endtask
  function automatic bit busy();
    for (int i = 0; i < NS; i++) if (stim[i].size() > 0 || mq[i].size() > 0) return 1;
    return 0;
  endfunction
  task automatic run(input int rate);
    int c = 0;
    while (busy() && c < 400) begin
      step(rate, 0);
      c++;
    end
    repeat (3) step(rate, 0);
    check("drain_bound", 256'(c < 400), 256'(1));
  endtask
  initial begin
    repeat (3) step(100, 1);
    for (int i = 0; i < NS; i++) stim[i].push_back({5'(i + 1), $urandom});
    run(100);
    stim[1].push_back({5'd7, 32'hDEADBEEF});
    run(100);
    stim[0].push_back({5'd9, 32'h0000_0A0A});
    stim[1].push_back({5'd9, 32'h0000_0B0B});
    run(100);
    for (int n = 0; n < 4; n++) begin
      stim[2].push_back({5'd12, 32'h2000_0000 + 32'(n)});
      stim[3].push_back({5'(13 + n), 32'h3000_0000 + 32'(n)});
    end
    run(100);
    stim[4].push_back({5'd0, 32'd5});
    run(100);
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < NS; i++)
        repeat (15) stim[i].push_back({5'($urandom_range(0, 7)), $urandom});
      repeat (40) step(70, 0);
      if (round[0]) repeat (2) step(70, 1);
      run(60 + 10 * round);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
